sys_mem_slave: RTL and testbench

System-side memory slave that sits directly downstream of the cache controller's system port and services its S_strobe/S_rw transactions. It captures one request at a time, holds it for a fixed number of wait states that matches the controller's wait-state counter, then completes it with a one-cycle acknowledge. Reads return data on S_rdata. Writes commit to an internal word array with byte enables. Out-of-range accesses and protocol violations are flagged.

---
 rtl/sys_mem_slave.sv | 137 +++++++++++++
 tb/tb_sys_mem_slave.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_mem_slave.sv
// sys_mem_slave: system-side memory slave for the cache controller's system port.
// Takes one request at a time, waits WAIT_STATES cycles, then completes it with a
// one-cycle acknowledge. Reads return registered data. Writes commit with byte
// enables. Accesses at or beyond DEPTH are flagged, and a strobe that arrives
// while a request is in flight raises a sticky protocol-error flag.
module sys_mem_slave #(
   parameter int unsigned WAIT_STATES = 2,     // legal range 1..15
   parameter int unsigned DATA_W      = 32,    // multiple of 8
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned DEPTH       = 1024   // <= 2**ADDR_W, any value
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                S_strobe,
   input  logic                S_rw,
   input  logic [ADDR_W-1:0]   S_addr,
   input  logic [DATA_W-1:0]   S_wdata,
   input  logic [DATA_W/8-1:0] S_be,
   output logic [DATA_W-1:0]   S_rdata,
   output logic                S_rdata_valid,
   output logic                S_ack,
   output logic                S_busy,
   output logic                S_err,
   output logic                proto_err
);

   localparam int unsigned     BE_W     = DATA_W / 8;
   localparam int unsigned     IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so DEPTH == 2**ADDR_W is representable in the range compare.
   localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
   localparam logic [3:0]      CNT_LOAD = 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t              state_q;
   logic [3:0]          cnt_q;
   logic                rw_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [BE_W-1:0]     be_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                rdata_valid_q;
   logic                ack_q;
   logic                busy_q;
   logic                err_q;
   logic                proto_err_q;

   // NOTE: the word array has no reset; its contents are undefined after power-up
   // and a reset loop over DEPTH words would prevent RAM inference.
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                in_range;
   logic [IDX_W-1:0]    mem_idx;

   assign in_range = ({1'b0, addr_q} < DEPTH_L);
   assign mem_idx  = addr_q[IDX_W-1:0];

   // Request sequencing: capture, wait-state countdown, one-cycle completion with
   // all handshake outputs registered so no input reaches an output combinationally.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         ack_q         <= 1'b0;
         busy_q        <= 1'b0;
         err_q         <= 1'b0;
         proto_err_q   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // read in this block sees the value from before the edge.
         ack_q         <= 1'b0;
         rdata_valid_q <= 1'b0;
         err_q         <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (S_strobe) begin
                  rw_q    <= S_rw;
                  addr_q  <= S_addr;
                  wdata_q <= S_wdata;
                  be_q    <= S_be;
                  cnt_q   <= CNT_LOAD;
                  busy_q  <= 1'b1;
                  state_q <= ST_WAIT;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (S_strobe) begin
                  proto_err_q <= 1'b1;
               end
               if (cnt_q == 4'd0) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  ack_q   <= 1'b1;
                  err_q   <= ~in_range;
                  if (rw_q) begin
                     rdata_valid_q <= 1'b1;
                     rdata_q       <= in_range ? mem_q[mem_idx] : '0;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Byte-enabled write commit on the edge that ends DONE; a reset edge cancels it.
   always_ff @(posedge clk) begin
      if (!rst && state_q == ST_DONE && !rw_q && in_range) begin
         for (int i = 0; i < BE_W; i++) begin
            if (be_q[i]) begin
               mem_q[mem_idx][i*8 +: 8] <= wdata_q[i*8 +: 8];
            end
         end
      end
   end

   assign S_rdata       = rdata_q;
   assign S_rdata_valid = rdata_valid_q;
   assign S_ack         = ack_q;
   assign S_busy        = busy_q;
   assign S_err         = err_q;
   assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_sys_mem_slave.sv
// tb_sys_mem_slave: drives sys_mem_slave with directed and random transactions.
// Expected responses come from a word-array model and are queued at issue time;
// a negedge monitor pops and compares them whenever the slave acknowledges.
module tb_sys_mem_slave;

   localparam int WS     = 3;
   localparam int DW     = 32;
   localparam int AW     = 10;
   localparam int DEPTH  = 1000;
   localparam int NEVER  = 32'h7fff_ffff;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          S_strobe = 1'b0;
   logic          S_rw = 1'b0;
   logic [AW-1:0] S_addr = '0;
   logic [DW-1:0] S_wdata = '0;
   logic [3:0]    S_be = '0;
   logic [DW-1:0] S_rdata;
   logic          S_rdata_valid;
   logic          S_ack;
   logic          S_busy;
   logic          S_err;
   logic          proto_err;

   sys_mem_slave #(
      .WAIT_STATES (WS),
      .DATA_W      (DW),
      .ADDR_W      (AW),
      .DEPTH       (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .S_strobe      (S_strobe),
      .S_rw          (S_rw),
      .S_addr        (S_addr),
      .S_wdata       (S_wdata),
      .S_be          (S_be),
      .S_rdata       (S_rdata),
      .S_rdata_valid (S_rdata_valid),
      .S_ack         (S_ack),
      .S_busy        (S_busy),
      .S_err         (S_err),
      .proto_err     (proto_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cap;
      int          ack_cyc;
      bit          rd;
      bit          err;
      logic [31:0] data;
      logic [31:0] mask;
   } exp_t;

   exp_t        sb_q[$];
   int          total = 0;
   int          bad = 0;
   bit          mon_en = 1'b0;
   int          proto_from = NEVER;

   // Reference memory: value plus a mask of bits that have ever been written.
   logic [31:0] m_data  [DEPTH];
   logic [31:0] m_known [DEPTH];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Issue one request now (it is captured on the next edge), queue its expected
   // response, then wait until its acknowledge is visible; returns in the ack cycle.
   task automatic do_txn(input bit rw, input int addr, input logic [31:0] wdata,
                         input logic [3:0] be, input bit pulse_in_wait);
      exp_t e;
      bit   oor;
      oor       = (addr >= DEPTH);
      e.cap     = cyc + 1;
      e.ack_cyc = cyc + 1 + WS;
      e.rd      = rw;
      e.err     = oor;
      e.data    = '0;
      e.mask    = '1;
      if (rw) begin
         if (!oor) begin
            e.data = m_data[addr];
            e.mask = m_known[addr];
         end
      end else if (!oor) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               m_data[addr][b*8 +: 8]  = wdata[b*8 +: 8];
               m_known[addr][b*8 +: 8] = 8'hff;
            end
         end
      end
      sb_q.push_back(e);
      S_strobe = 1'b1;
      S_rw     = rw;
      S_addr   = AW'(addr);
      S_wdata  = wdata;
      S_be     = be;
      @(posedge clk); #1;
      S_strobe = 1'b0;
      if (pulse_in_wait) begin
         // Stray request while the first is in flight: must be ignored.
         S_strobe   = 1'b1;
         S_rw       = ~rw;
         S_addr     = AW'(addr + 1);
         S_wdata    = ~wdata;
         S_be       = 4'hf;
         proto_from = cyc + 1;
         @(posedge clk); #1;
         S_strobe = 1'b0;
      end
      for (int i = 0; i < 64 && !S_ack; i++) begin
         @(posedge clk); #1;
      end
      if (!S_ack) check("ack_timeout", {31'b0, S_ack}, 32'd1);
   endtask

   task automatic idle(input int n);
      S_strobe = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Monitor: per-cycle busy/proto_err checks and scoreboard pop on every ack.
   always @(negedge clk) begin
      exp_t e;
      bit   exp_busy;
      if (mon_en && !rst) begin
         exp_busy = (sb_q.size() > 0) && (cyc >= sb_q[0].cap) && (cyc < sb_q[0].cap + WS);
         check("busy", {31'b0, S_busy}, {31'b0, exp_busy});
         check("proto_err", {31'b0, proto_err}, {31'b0, (cyc >= proto_from)});
         if (S_ack) begin
            if (sb_q.size() == 0) begin
               check("spurious_ack", {31'b0, S_ack}, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("ack_cycle", cyc, e.ack_cyc);
               check("err", {31'b0, S_err}, {31'b0, e.err});
               check("rdata_valid", {31'b0, S_rdata_valid}, {31'b0, e.rd});
               if (e.rd) check("rdata", S_rdata & e.mask, e.data & e.mask);
            end
         end else begin
            check("rdata_valid_idle", {31'b0, S_rdata_valid}, 32'd0);
            if (sb_q.size() > 0 && cyc > sb_q[0].ack_cyc) begin
               check("missing_ack", {31'b0, S_ack}, 32'd1);
               void'(sb_q.pop_front());
            end
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ack"},   {31'b0, S_ack},         32'd0);
      check({tag, "_valid"}, {31'b0, S_rdata_valid}, 32'd0);
      check({tag, "_err"},   {31'b0, S_err},         32'd0);
      check({tag, "_busy"},  {31'b0, S_busy},        32'd0);
      check({tag, "_proto"}, {31'b0, proto_err},     32'd0);
      check({tag, "_rdata"}, S_rdata,                32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int a = 0; a < DEPTH; a++) begin
         m_data[a]  = '0;
         m_known[a] = '0;
      end

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst    = 1'b0;
      mon_en = 1'b1;
      idle(2);

      // Full-word write then read.
      do_txn(1'b0, 5, 32'hDEADBEEF, 4'hF, 1'b0);
      do_txn(1'b1, 5, 32'h0, 4'h0, 1'b0);
      idle(1);
      check("rdata_addr5", S_rdata, 32'hDEADBEEF);

      // Byte enables.
      do_txn(1'b0, 7, 32'hFFFFFFFF, 4'hF, 1'b0);
      do_txn(1'b0, 7, 32'h12345678, 4'b0101, 1'b0);
      do_txn(1'b1, 7, 32'h0, 4'h0, 1'b0);
      idle(1);
      check("rdata_addr7", S_rdata, 32'hFF34FF78);

      // Out of range: edges of the implemented space stay intact.
      do_txn(1'b0, 0, 32'h0BAD_F00D, 4'hF, 1'b0);
      do_txn(1'b0, DEPTH - 1, 32'hCAFE_0999, 4'hF, 1'b0);
      do_txn(1'b0, DEPTH, 32'h5555_AAAA, 4'hF, 1'b0);
      do_txn(1'b1, DEPTH, 32'h0, 4'h0, 1'b0);
      do_txn(1'b0, 1023, 32'h7777_7777, 4'hF, 1'b0);
      do_txn(1'b1, 1023, 32'h0, 4'h0, 1'b0);
      do_txn(1'b1, 0, 32'h0, 4'h0, 1'b0);
      do_txn(1'b1, DEPTH - 1, 32'h0, 4'h0, 1'b0);
      do_txn(1'b1, DEPTH - 1 - 24, 32'h0, 4'h0, 1'b0);
      idle(2);

      // Back-to-back: read captured in the write's DONE cycle sees the new data.
      do_txn(1'b0, 2, 32'hA5A5A5A5, 4'hF, 1'b0);
      do_txn(1'b1, 2, 32'h0, 4'h0, 1'b0);
      idle(2);

      // Protocol violation: stray strobe in WAIT, original ack on time, flag sticky.
      do_txn(1'b0, 9, 32'h0F0F_0F0F, 4'hF, 1'b1);
      do_txn(1'b1, 9, 32'h0, 4'h0, 1'b0);
      idle(3);

      // Reset in the middle of a write: no ack, no commit, outputs back to reset.
      do_txn(1'b0, 3, 32'h11111111, 4'hF, 1'b0);
      idle(2);
      mon_en   = 1'b0;
      S_strobe = 1'b1;
      S_rw     = 1'b0;
      S_addr   = AW'(3);
      S_wdata  = 32'h22222222;
      S_be     = 4'hF;
      @(posedge clk); #1;
      S_strobe = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      proto_from = NEVER;
      check_reset_outputs("midrst");
      repeat (WS + 2) begin
         @(posedge clk); #1;
         check("no_ack_after_rst", {31'b0, S_ack}, 32'd0);
      end
      mon_en = 1'b1;
      do_txn(1'b1, 3, 32'h0, 4'h0, 1'b0);
      idle(1);
      check("rdata_addr3", S_rdata, 32'h11111111);

      // Random traffic over a small hot set plus the out-of-range boundary.
      for (int n = 0; n < 80; n++) begin
         int addr;
         if ($urandom_range(0, 3) == 0) addr = int'($urandom_range(DEPTH - 10, 1023));
         else                           addr = int'($urandom_range(0, 15));
         do_txn(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)), 1'b0);
         idle(int'($urandom_range(0, 2)));
      end

      idle(WS + 3);
      check("queue_drained", sb_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
